// File: rtl/realram_ctrl_pkg.sv
// ============================================================================
// Module   : realram_ctrl_pkg
// Brief    : Shared types and sizing helpers for the sky130 8x1024 RW-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package realram_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int c_DEFAULT_NUM_REQ = 2;
  localparam int c_DEFAULT_DEPTH   = 1024;
  localparam int c_DEFAULT_BITS    = 8;

  // Requester index width; a single requester still needs a 1-bit id.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/realram_rr_arbiter.sv
// ============================================================================
// Module   : realram_rr_arbiter
// Brief    : Round-robin priority picker; first request at or after ptr wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module realram_rr_arbiter
  import realram_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = c_DEFAULT_NUM_REQ,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_rot_gnt;
  logic [2*NUM_REQ-1:0] w_gnt_dbl;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  assign w_req_dbl = {req, req};
  assign w_rot     = w_req_dbl[ptr +: NUM_REQ];
  assign w_rot_gnt = w_rot & (~w_rot + 1'b1);
  assign w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << ptr;
  assign grant     = w_gnt_dbl[2*NUM_REQ-1:NUM_REQ];

endmodule

`default_nettype wire

// File: rtl/realram_8x1024_arbiter.sv
// ============================================================================
// Module   : realram_8x1024_arbiter
// Brief    : Shares port 0 of a sky130 1rw1r 8x1024 macro between NUM_REQ
//            requesters with round-robin grant, clear sweep and read tagging.
// Revision : 1.0
// ============================================================================
`default_nettype none

module realram_8x1024_arbiter
  import realram_ctrl_pkg::*;
#(
  parameter int                NUM_REQ        = c_DEFAULT_NUM_REQ,
  parameter int                ADDR_WIDTH     = $clog2(c_DEFAULT_DEPTH),
  parameter int                BITS           = c_DEFAULT_BITS,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [BITS-1:0]   CLEAR_VALUE    = '0,
  localparam int               ID_WIDTH       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_v,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITS-1:0]       req_wdata,
  input  logic [NUM_REQ*BITS-1:0]       req_wmask,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_v,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [BITS-1:0]               rsp_data,
  output logic                          clear_done,
  output logic                          sram_csb0,
  output logic                          sram_web0,
  output logic [BITS-1:0]               sram_wmask0,
  output logic [ADDR_WIDTH-1:0]         sram_addr0,
  output logic [BITS-1:0]               sram_din0,
  input  logic [BITS-1:0]               sram_dout0
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;
  localparam state_t                c_RESET_ST  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [ADDR_WIDTH-1:0]          r_count;
  logic [ID_WIDTH-1:0]            r_ptr;
  logic [ID_WIDTH-1:0]            w_ptr_nxt;
  logic [NUM_REQ-1:0]             w_req_eff;
  logic [NUM_REQ-1:0]             w_grant;
  logic                           w_any_req;
  logic                           w_accept;

  logic [ADDR_WIDTH-1:0]          w_addr_acc  [NUM_REQ+1];
  logic [BITS-1:0]                w_wdata_acc [NUM_REQ+1];
  logic [BITS-1:0]                w_wmask_acc [NUM_REQ+1];
  logic [ID_WIDTH-1:0]            w_id_acc    [NUM_REQ+1];
  logic                           w_we_acc    [NUM_REQ+1];

  logic [ADDR_WIDTH-1:0]          r_last_addr;
  logic [BITS-1:0]                r_last_din;
  logic [BITS-1:0]                r_last_wmask;

  logic                           r_iss_v;
  logic [ID_WIDTH-1:0]            r_iss_id;
  logic [READ_LATENCY-1:0]                r_tag_v;
  logic [READ_LATENCY-1:0][ID_WIDTH-1:0]  r_tag_id;

  // Requests only compete once the array is usable and reset has released.
  assign w_req_eff = (r_state == ST_RUN && !reset) ? req_v : '0;
  assign w_any_req = |w_req_eff;

  realram_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req   (w_req_eff),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Grant is one-hot, so the winner's fields are an OR of masked slices.
  assign w_addr_acc[0]  = '0;
  assign w_wdata_acc[0] = '0;
  assign w_wmask_acc[0] = '0;
  assign w_id_acc[0]    = '0;
  assign w_we_acc[0]    = 1'b0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_win_mux
    assign w_addr_acc[i+1]  = w_addr_acc[i]  | (w_grant[i] ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : '0);
    assign w_wdata_acc[i+1] = w_wdata_acc[i] | (w_grant[i] ? req_wdata[i*BITS +: BITS] : '0);
    assign w_wmask_acc[i+1] = w_wmask_acc[i] | (w_grant[i] ? req_wmask[i*BITS +: BITS] : '0);
    assign w_id_acc[i+1]    = w_id_acc[i]    | (w_grant[i] ? ID_WIDTH'(i) : '0);
    assign w_we_acc[i+1]    = w_we_acc[i]    | (w_grant[i] & req_we[i]);
  end

  assign w_accept  = |(req_v & w_grant);
  assign w_ptr_nxt = (w_id_acc[NUM_REQ] == ID_WIDTH'(NUM_REQ - 1)) ? '0
                   : w_id_acc[NUM_REQ] + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_RESET_ST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_count == c_LAST_ADDR) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = c_RESET_ST;
    endcase
  end

  // Idle macro pins replay the last driven values to avoid needless toggling.
  always_comb begin
    req_ready   = '0;
    clear_done  = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_addr0  = r_last_addr;
    sram_din0   = r_last_din;
    sram_wmask0 = r_last_wmask;
    if (!reset) begin
      case (r_state)
        ST_CLEAR: begin
          sram_csb0   = 1'b0;
          sram_web0   = 1'b0;
          sram_addr0  = r_count;
          sram_din0   = CLEAR_VALUE;
          sram_wmask0 = '1;
        end
        ST_RUN: begin
          clear_done = 1'b1;
          req_ready  = w_grant;
          if (w_any_req) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~w_we_acc[NUM_REQ];
            sram_addr0  = w_addr_acc[NUM_REQ];
            sram_din0   = w_wdata_acc[NUM_REQ];
            sram_wmask0 = w_wmask_acc[NUM_REQ];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_ptr        <= '0;
      r_last_addr  <= '0;
      r_last_din   <= '0;
      r_last_wmask <= '0;
      r_iss_v      <= 1'b0;
      r_iss_id     <= '0;
    end else begin
      if (r_state == ST_CLEAR && r_count != c_LAST_ADDR) begin
        r_count <= r_count + 1'b1;
      end
      if (w_accept) begin
        r_ptr <= w_ptr_nxt;
      end
      if (!sram_csb0) begin
        r_last_addr  <= sram_addr0;
        r_last_din   <= sram_din0;
        r_last_wmask <= sram_wmask0;
      end
      r_iss_v  <= w_accept & ~w_we_acc[NUM_REQ];
      r_iss_id <= w_id_acc[NUM_REQ];
    end
  end

  // The issue stage plus READ_LATENCY tag stages line up with dout0 validity.
  if (READ_LATENCY == 1) begin : g_tag_lat1
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_tag_v  <= '0;
        r_tag_id <= '0;
      end else begin
        r_tag_v     <= r_iss_v;
        r_tag_id[0] <= r_iss_id;
      end
    end
  end else begin : g_tag_latn
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_tag_v  <= '0;
        r_tag_id <= '0;
      end else begin
        r_tag_v  <= {r_tag_v[READ_LATENCY-2:0], r_iss_v};
        r_tag_id <= {r_tag_id[READ_LATENCY-2:0], r_iss_id};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_v    <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      rsp_v <= r_tag_v[READ_LATENCY-1];
      if (r_tag_v[READ_LATENCY-1]) begin
        rsp_id   <= r_tag_id[READ_LATENCY-1];
        rsp_data <= sram_dout0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_realram_8x1024_arbiter.sv
// ============================================================================
// Module   : tb_realram_8x1024_arbiter
// Brief    : Directed self-checking bench with a behavioural 1-cycle-latency macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_realram_8x1024_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_v;
  logic [1:0]  req_we;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] req_wmask;
  logic [1:0]  req_ready;
  logic        rsp_v;
  logic [0:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        clear_done;
  logic        sram_csb0;
  logic        sram_web0;
  logic [7:0]  sram_wmask0;
  logic [9:0]  sram_addr0;
  logic [7:0]  sram_din0;
  logic [7:0]  sram_dout0;

  int n_tests = 0;
  int n_fail  = 0;

  realram_8x1024_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_v       (req_v),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .req_ready   (req_ready),
    .rsp_v       (rsp_v),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .clear_done  (clear_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: read captured at edge E, dout0 valid from edge E+1.
  logic [7:0] mem [0:1023];
  logic [7:0] mem_q;
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= (mem[sram_addr0] & ~sram_wmask0) | (sram_din0 & sram_wmask0);
      else            mem_q <= mem[sram_addr0];
    end
    sram_dout0 <= mem_q;
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] m0, input logic [7:0] m1);
    req_v     = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_wmask = {m1, m0};
  endtask

  task automatic idle_reqs();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    drive(2'b01, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_v: got %b want 0", rsp_v); end
    n_tests++; if (rsp_id !== 1'b0 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp: got id %b data %h want 0/00", rsp_id, rsp_data); end
    n_tests++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_clear_done: got %b want 0", clear_done); end
    n_tests++; if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin n_fail++; $display("FAIL reset_macro: got csb %b web %b want 1/1", sram_csb0, sram_web0); end
  endtask

  task automatic test_clear_sweep();
    int bad = 0;
    int first_bad = -1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 1024; c++) begin
      #1;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 10'(c) ||
          sram_wmask0 !== 8'hFF || sram_din0 !== 8'h00 || req_ready !== 2'b00 || clear_done !== 1'b0) begin
        if (bad == 0) first_bad = c;
        bad++;
      end
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sweep_cycles: %0d bad cycles (first at %0d) want 0", bad, first_bad); end
    #1;
    n_tests++; if (clear_done !== 1'b1) begin n_fail++; $display("FAIL sweep_done: got %b want 1", clear_done); end
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL sweep_first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    idle_reqs();
    n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL sweep_rsp_early1: got %b want 0", rsp_v); end
    @(negedge clk);
    n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL sweep_rsp_early2: got %b want 0", rsp_v); end
    @(negedge clk);
    n_tests++; if (rsp_v !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h00) begin
      n_fail++; $display("FAIL sweep_readback: got v %b id %b data %h want 1/0/00", rsp_v, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drive(2'b01, 2'b01, 10'd12, 10'd0, 8'hA5, 8'h00, 8'hFF, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b01 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 10'd12) begin
      n_fail++; $display("FAIL wr_issue: got rdy %b csb %b web %b addr %0d want 01/0/0/12", req_ready, sram_csb0, sram_web0, sram_addr0); end
    @(negedge clk);
    drive(2'b01, 2'b00, 10'd12, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b01 || sram_web0 !== 1'b1) begin n_fail++; $display("FAIL rd_issue: got rdy %b web %b want 01/1", req_ready, sram_web0); end
    @(negedge clk);
    idle_reqs();
    n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL rd_early1: got %b want 0", rsp_v); end
    @(negedge clk);
    n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL rd_early2: got %b want 0", rsp_v); end
    @(negedge clk);
    n_tests++; if (rsp_v !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'hA5) begin
      n_fail++; $display("FAIL rd_data: got v %b id %b data %h want 1/0/a5", rsp_v, rsp_id, rsp_data); end
    @(negedge clk);
    n_tests++; if (rsp_v !== 1'b0 || rsp_data !== 8'hA5) begin n_fail++; $display("FAIL rd_pulse: got v %b data %h want 0/a5", rsp_v, rsp_data); end
  endtask

  task automatic test_wmask();
    drive(2'b10, 2'b10, 10'd0, 10'd5, 8'h00, 8'hFF, 8'h00, 8'hFF);
    @(negedge clk);
    drive(2'b01, 2'b01, 10'd5, 10'd0, 8'h00, 8'h00, 8'h0F, 8'h00);
    #1;
    n_tests++; if (sram_wmask0 !== 8'h0F || sram_din0 !== 8'h00) begin n_fail++; $display("FAIL mask_pins: got mask %h din %h want 0f/00", sram_wmask0, sram_din0); end
    @(negedge clk);
    drive(2'b10, 2'b00, 10'd0, 10'd5, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL mask_rd_grant: got %b want 10", req_ready); end
    @(negedge clk);
    idle_reqs();
    repeat (2) @(negedge clk);
    n_tests++; if (rsp_v !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'hF0) begin
      n_fail++; $display("FAIL mask_data: got v %b id %b data %h want 1/1/f0", rsp_v, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if (i >= 3) begin
        n_tests++;
        if (rsp_v !== 1'b1 || rsp_id !== 1'((i - 3) % 2) || rsp_data !== (((i - 3) % 2 == 0) ? 8'hA5 : 8'hF0)) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got v %b id %b data %h", i, rsp_v, rsp_id, rsp_data);
        end
      end else begin
        n_tests++; if (rsp_v !== 1'b0) begin n_fail++; $display("FAIL b2b_quiet%0d: got %b want 0", i, rsp_v); end
      end
      if (i < 5) begin
        drive(2'b11, 2'b00, 10'd12, 10'd5, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        n_tests++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", i, req_ready, ((i % 2 == 0) ? 2'b01 : 2'b10));
        end
      end else begin
        idle_reqs();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || req_ready !== 2'b00 || sram_addr0 !== 10'd12) bad++;
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_pins: %0d bad cycles want 0", bad); end
    drive(2'b11, 2'b00, 10'd12, 10'd5, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL idle_ptr_held: got %b want 10", req_ready); end
    drive(2'b01, 2'b01, 10'd12, 10'd0, 8'hA5, 8'h00, 8'hFF, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b01 || sram_csb0 !== 1'b0) begin n_fail++; $display("FAIL idle_single: got rdy %b csb %b want 01/0", req_ready, sram_csb0); end
    @(negedge clk);
    idle_reqs();
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    drive(2'b01, 2'b00, 10'd12, 10'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL abort_grant: got %b want 01", req_ready); end
    @(negedge clk);
    idle_reqs();
    reset = 1'b1;
    #1;
    n_tests++; if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || req_ready !== 2'b00 || clear_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got csb %b web %b rdy %b done %b want 1/1/00/0", sram_csb0, sram_web0, req_ready, clear_done); end
    n_tests++; if (rsp_data !== 8'h00 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_regs: got id %b data %h want 0/00", rsp_id, rsp_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_v !== 1'b0) bad++;
    end
    reset = 1'b0;
    #1;
    n_tests++; if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 10'd0) begin
      n_fail++; $display("FAIL abort_restart: got csb %b web %b addr %0d want 0/0/0", sram_csb0, sram_web0, sram_addr0); end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (rsp_v !== 1'b0 || sram_addr0 !== 10'(i)) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_no_rsp: %0d bad cycles want 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    idle_reqs();
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_wmask();
    test_back_to_back();
    test_idle();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
